elm_argmax_classifier: RTL and testbench

- Upstream stage of the one-hot digit decoder.
- Consumes the stream of NUM_CLASSES signed output-neuron scores that the ELM output layer produces for one image.
- Tracks the running maximum and emits the winning class index as count_data[3:0].
- Issues the rst_digit and en_digit control pulses consumed by the digit decoder.

---
 rtl/elm_argmax_classifier_if.sv | 36 +++
 rtl/elm_argmax_classifier.sv | 116 +++++++++++
 tb/tb_elm_argmax_classifier.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/elm_argmax_classifier_if.sv
// Score stream in, digit-decoder controls out.
// The master drives frames; the slave is the classifier.
interface elm_argmax_classifier_if #(
    parameter int SCORE_W = 16
);
    logic                      start;
    logic                      score_valid;
    logic signed [SCORE_W-1:0] score_data;
    logic                      score_ready;
    logic [3:0]                count_data;
    logic                      en_digit;
    logic                      rst_digit;
    logic                      busy;

    modport master (
        output start,
        output score_valid,
        output score_data,
        input  score_ready,
        input  count_data,
        input  en_digit,
        input  rst_digit,
        input  busy
    );

    modport slave (
        input  start,
        input  score_valid,
        input  score_data,
        output score_ready,
        output count_data,
        output en_digit,
        output rst_digit,
        output busy
    );
endinterface

// File: rtl/elm_argmax_classifier.sv
// Running signed argmax over one frame of ELM output scores.
// Emits the winning class index and the digit-decoder pulses.
module elm_argmax_classifier #(
    parameter int SCORE_W     = 16,
    parameter int NUM_CLASSES = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    elm_argmax_classifier_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] LAST = 4'(NUM_CLASSES - 1);

    state_t                    state_q, state_d;
    logic signed [SCORE_W-1:0] max_q, max_d;
    logic [3:0]                idx_q, idx_d;
    logic [3:0]                best_q, best_d;
    logic [3:0]                count_q, count_d;
    logic                      en_digit_q, en_digit_d;
    logic                      rst_digit_q, rst_digit_d;
    logic                      ready_q, ready_d;
    logic                      busy_q, busy_d;

    logic accept;
    logic take;

    assign accept = (state_q == ACCUM) && ready_q
                  && bus.score_valid && !bus.start;
    // First score of a frame always seeds the running maximum.
    assign take = (idx_q == 4'd0) || (bus.score_data > max_q);

    always_comb begin
        state_d     = state_q;
        max_d       = max_q;
        idx_d       = idx_q;
        best_d      = best_q;
        count_d     = count_q;
        en_digit_d  = 1'b0;
        rst_digit_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d     = ACCUM;
                    idx_d       = 4'd0;
                    best_d      = 4'd0;
                    rst_digit_d = 1'b1;
                end
            end
            ACCUM: begin
                if (bus.start) begin
                    idx_d       = 4'd0;
                    best_d      = 4'd0;
                    rst_digit_d = 1'b1;
                end else if (accept) begin
                    if (take) begin
                        max_d  = bus.score_data;
                        best_d = idx_q;
                    end
                    idx_d = idx_q + 4'd1;
                    if (idx_q == LAST) begin
                        state_d    = DONE;
                        en_digit_d = 1'b1;
                        count_d    = take ? idx_q : best_q;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                if (bus.start) begin
                    state_d     = ACCUM;
                    idx_d       = 4'd0;
                    best_d      = 4'd0;
                    rst_digit_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == ACCUM);
        busy_d  = (state_d == ACCUM);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            max_q       <= '0;
            idx_q       <= '0;
            best_q      <= '0;
            count_q     <= '0;
            en_digit_q  <= 1'b0;
            rst_digit_q <= 1'b0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            max_q       <= max_d;
            idx_q       <= idx_d;
            best_q      <= best_d;
            count_q     <= count_d;
            en_digit_q  <= en_digit_d;
            rst_digit_q <= rst_digit_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.score_ready = ready_q;
    assign bus.count_data  = count_q;
    assign bus.en_digit    = en_digit_q;
    assign bus.rst_digit   = rst_digit_q;
    assign bus.busy        = busy_q;
endmodule

// File: tb/tb_elm_argmax_classifier.sv
// Directed frames for the argmax classifier: table of frames
// plus chained, aborted and reset-interrupted sequences.
module tb_elm_argmax_classifier;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    elm_argmax_classifier_if #(.SCORE_W(16)) bus ();

    elm_argmax_classifier #(
        .SCORE_W(16),
        .NUM_CLASSES(10)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic signed [15:0] s [10];
        bit                 gaps;
        logic [3:0]         exp;
    } vec_t;

    vec_t               tbl [5];
    logic signed [15:0] cur [10];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Entered and left at a negedge; pre means start was already
    // raised by the caller at the current negedge.
    task automatic run_frame(input bit pre, input bit chain,
                             input bit gaps, input logic [3:0] exp,
                             input string tag);
        int en_seen = 0;
        int rd_seen = 0;
        if (!pre) bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk({tag, " rst_digit"}, int'(bus.rst_digit), 1);
        chk({tag, " en_digit_at_start"}, int'(bus.en_digit), 0);
        chk({tag, " busy"}, int'(bus.busy), 1);
        for (int i = 0; i < 10; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    bus.score_valid = 1'b0;
                    bus.score_data  = 16'sh7fff;
                    @(negedge clk);
                    en_seen += int'(bus.en_digit);
                    rd_seen += int'(bus.rst_digit);
                end
            end
            bus.score_valid = 1'b1;
            bus.score_data  = cur[i];
            @(negedge clk);
            if (i < 9) begin
                en_seen += int'(bus.en_digit);
                rd_seen += int'(bus.rst_digit);
            end
        end
        bus.score_valid = 1'b0;
        chk({tag, " early_en"}, en_seen, 0);
        chk({tag, " extra_rst_digit"}, rd_seen, 0);
        chk({tag, " en_digit"}, int'(bus.en_digit), 1);
        chk({tag, " rst_digit_in_done"}, int'(bus.rst_digit), 0);
        chk({tag, " count_data"}, int'(bus.count_data), int'(exp));
        if (chain) begin
            bus.start = 1'b1;
            return;
        end
        @(negedge clk);
        chk({tag, " en_one_cycle"}, int'(bus.en_digit), 0);
        chk({tag, " busy_after"}, int'(bus.busy), 0);
        chk({tag, " ready_after"}, int'(bus.score_ready), 0);
        chk({tag, " count_held"}, int'(bus.count_data), int'(exp));
    endtask

    initial begin
        int en_seen;

        tbl[0].s = '{16'sd5, -16'sd3, 16'sd12, 16'sd7, 16'sd0,
                     16'sd1, 16'sd2, 16'sd3, 16'sd4, -16'sd8};
        tbl[0].gaps = 1'b0;
        tbl[0].exp  = 4'd2;
        tbl[1].s = '{-16'sd20, -16'sd5, -16'sd9, -16'sd30, -16'sd40,
                     -16'sd50, -16'sd60, -16'sd70, -16'sd80, -16'sd100};
        tbl[1].gaps = 1'b0;
        tbl[1].exp  = 4'd1;
        tbl[2].s = '{16'sd1, 16'sd2, 16'sd3, 16'sd9, 16'sd0,
                     16'sd4, 16'sd5, 16'sd9, 16'sd8, 16'sd7};
        tbl[2].gaps = 1'b0;
        tbl[2].exp  = 4'd3;
        tbl[3].s = '{16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0,
                     16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sh7fff};
        tbl[3].gaps = 1'b1;
        tbl[3].exp  = 4'd9;
        tbl[4].s = '{16'sh8000, 16'sh8000, 16'sh8000, 16'sh8000,
                     16'sh8000, 16'sh8001, 16'sh8000, 16'sh8001,
                     16'sh8000, 16'sh8000};
        tbl[4].gaps = 1'b1;
        tbl[4].exp  = 4'd5;

        bus.start       = 1'b0;
        bus.score_valid = 1'b0;
        bus.score_data  = '0;
        repeat (3) @(negedge clk);
        chk("reset count_data", int'(bus.count_data), 0);
        chk("reset en_digit", int'(bus.en_digit), 0);
        chk("reset rst_digit", int'(bus.rst_digit), 0);
        chk("reset score_ready", int'(bus.score_ready), 0);
        chk("reset busy", int'(bus.busy), 0);
        rst = 1'b1;
        bus.score_valid = 1'b1;
        bus.score_data  = 16'sd100;
        @(negedge clk);
        chk("idle ignores valid", int'(bus.score_ready), 0);
        bus.score_valid = 1'b0;

        // Vector 1 chains straight into vector 2 via start in DONE.
        for (int v = 0; v < 5; v++) begin
            cur = tbl[v].s;
            run_frame(v == 2, v == 1, tbl[v].gaps, tbl[v].exp,
                      $sformatf("vec%0d", v));
        end

        // Abort: four scores, restart with a discarded score.
        en_seen = 0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("abort rst_digit1", int'(bus.rst_digit), 1);
        for (int i = 0; i < 4; i++) begin
            bus.score_valid = 1'b1;
            bus.score_data  = 16'(100 * (i + 1));
            @(negedge clk);
            en_seen += int'(bus.en_digit);
        end
        cur = '{16'sd1, 16'sd2, 16'sd3, 16'sd4, 16'sd5,
                16'sd6, 16'sd50, 16'sd7, 16'sd8, 16'sd9};
        bus.start       = 1'b1;
        bus.score_valid = 1'b1;
        bus.score_data  = 16'sd1000;
        run_frame(1'b1, 1'b0, 1'b0, 4'd6, "abort");
        chk("abort no en from partial", en_seen, 0);

        // Reset mid-frame.
        en_seen = 0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.score_valid = 1'b1;
            bus.score_data  = 16'sd500;
            @(negedge clk);
            en_seen += int'(bus.en_digit);
        end
        bus.score_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("midrst count_data", int'(bus.count_data), 0);
        chk("midrst busy", int'(bus.busy), 0);
        chk("midrst score_ready", int'(bus.score_ready), 0);
        chk("midrst rst_digit", int'(bus.rst_digit), 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        en_seen += int'(bus.en_digit);
        chk("midrst no en", en_seen, 0);
        chk("midrst idle", int'(bus.busy), 0);
        cur = '{16'sd3, 16'sd1, 16'sd2, -16'sd4, 16'sd77,
                16'sd70, 16'sd76, 16'sd77, 16'sd0, 16'sd5};
        run_frame(1'b0, 1'b0, 1'b0, 4'd4, "postrst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
